// File: rtl/present_bus_pkg.sv
// Shared types for the PRESENT-80 bus master: FSM states, register map, bus bundle.
package present_bus_pkg;

  localparam int KEY_W = 80;
  localparam int BLK_W = 64;
  localparam int BUS_W = 32;

  localparam logic [2:0] ADDR_LOAD    = 3'd0;
  localparam logic [2:0] ADDR_KEY_LO  = 3'd1;
  localparam logic [2:0] ADDR_KEY_MID = 3'd2;
  localparam logic [2:0] ADDR_KEY_HI  = 3'd3;
  localparam logic [2:0] ADDR_DAT_LO  = 3'd4;
  localparam logic [2:0] ADDR_DAT_HI  = 3'd5;
  localparam logic [2:0] ADDR_RES_LO  = 3'd6;
  localparam logic [2:0] ADDR_RES_HI  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_WK3, S_WK2, S_WK1,
    S_WD5, S_WD4, S_LD, S_LCLR,
    S_WAIT, S_RD7, S_RD6, S_CAP,
    S_OUT
  } state_t;

  typedef struct packed {
    logic             cs_n;
    logic             write_n;
    logic             read_n;
    logic [2:0]       addr;
    logic [BUS_W-1:0] dat;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    cs_n: 1'b1, write_n: 1'b1, read_n: 1'b1,
    addr: 3'd0, dat: '0
  };

  // Select without strobes: the slave drops its load bit on this cycle
  localparam bus_t BUS_CLR = '{
    cs_n: 1'b0, write_n: 1'b1, read_n: 1'b1,
    addr: 3'd0, dat: '0
  };

  function automatic bus_t bus_wr(
    input logic [2:0]       a,
    input logic [BUS_W-1:0] d
  );
    return '{cs_n: 1'b0, write_n: 1'b0, read_n: 1'b1,
             addr: a, dat: d};
  endfunction

  function automatic bus_t bus_rd(input logic [2:0] a);
    return '{cs_n: 1'b0, write_n: 1'b1, read_n: 1'b0,
             addr: a, dat: '0};
  endfunction

endpackage

// File: rtl/present_wait_cnt.sv
// Clear/enable wait counter; tc flags the last cycle of the compute wait.
module present_wait_cnt #(
  parameter int LATENCY = 34,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // LATENCY=0 behaves like 1: the wait still lasts one cycle
  localparam logic [CNT_W-1:0] LAST =
    (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/present_bus_master.sv
// Stream-to-register-bus initiator for the PRESENT-80 peripheral.
// Optional PRESENT_BUS_MASTER_DONE_EN adds iDone to end the wait early.
module present_bus_master
  import present_bus_pkg::*;
#(
  parameter int LATENCY = 34,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             iReset_n,
  input  logic             iKey_valid,
  output logic             oKey_ready,
  input  logic [KEY_W-1:0] iKey,
  input  logic             iBlk_valid,
  output logic             oBlk_ready,
  input  logic [BLK_W-1:0] iBlk,
  output logic             oRes_valid,
  input  logic             iRes_ready,
  output logic [BLK_W-1:0] oRes,
  output logic             oChipselect_n,
  output logic             oWrite_n,
  output logic             oRead_n,
  output logic [2:0]       oAddress,
  output logic [BUS_W-1:0] odat,
  input  logic [BUS_W-1:0] idat,
`ifdef PRESENT_BUS_MASTER_DONE_EN
  input  logic             iDone,
`endif
  output logic             oBusy
);

  state_t           state;
  bus_t             bus;
  logic [KEY_W-1:0] key_sh;
  logic             key_dirty;
  logic [BLK_W-1:0] blk;
  logic             tc;
  logic             wait_done;
  logic             key_hs;
  logic             blk_hs;
  logic [KEY_W-1:0] key_nx;

  assign oKey_ready = (state == S_IDLE);
  assign oBlk_ready = (state == S_IDLE);
  assign oBusy      = (state != S_IDLE);
  assign key_hs     = iKey_valid & oKey_ready;
  assign blk_hs     = iBlk_valid & oBlk_ready;
  assign key_nx     = key_hs ? iKey : key_sh;

`ifdef PRESENT_BUS_MASTER_DONE_EN
  assign wait_done = tc | iDone;
`else
  assign wait_done = tc;
`endif

  present_wait_cnt #(
    .LATENCY(LATENCY),
    .CNT_W  (CNT_W)
  ) u_wait_cnt (
    .clk  (clk),
    .rst_n(iReset_n),
    .clr  (state != S_WAIT),
    .en   (state == S_WAIT),
    .tc   (tc)
  );

  // Bus is loaded with the access of the state being entered
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= S_IDLE;
      bus        <= BUS_IDLE;
      key_sh     <= '0;
      key_dirty  <= 1'b0;
      blk        <= '0;
      oRes       <= '0;
      oRes_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (key_hs) begin
            key_sh    <= iKey;
            key_dirty <= 1'b1;
          end
          if (blk_hs) begin
            blk <= iBlk;
            if (key_hs || key_dirty) begin
              state <= S_WK3;
              bus   <= bus_wr(ADDR_KEY_HI, key_nx[79:48]);
            end else begin
              state <= S_WD5;
              bus   <= bus_wr(ADDR_DAT_HI, iBlk[63:32]);
            end
          end
        end
        S_WK3: begin
          state <= S_WK2;
          bus   <= bus_wr(ADDR_KEY_MID, key_sh[47:16]);
        end
        S_WK2: begin
          state <= S_WK1;
          bus   <= bus_wr(ADDR_KEY_LO,
                          {16'h0, key_sh[15:0]});
        end
        S_WK1: begin
          key_dirty <= 1'b0;
          state     <= S_WD5;
          bus       <= bus_wr(ADDR_DAT_HI, blk[63:32]);
        end
        S_WD5: begin
          state <= S_WD4;
          bus   <= bus_wr(ADDR_DAT_LO, blk[31:0]);
        end
        S_WD4: begin
          state <= S_LD;
          bus   <= bus_wr(ADDR_LOAD, 32'd1);
        end
        S_LD: begin
          state <= S_LCLR;
          bus   <= BUS_CLR;
        end
        S_LCLR: begin
          state <= S_WAIT;
          bus   <= BUS_IDLE;
        end
        S_WAIT: begin
          if (wait_done) begin
            state <= S_RD7;
            bus   <= bus_rd(ADDR_RES_HI);
          end
        end
        S_RD7: begin
          state <= S_RD6;
          bus   <= bus_rd(ADDR_RES_LO);
        end
        S_RD6: begin
          oRes[63:32] <= idat;
          state       <= S_CAP;
          bus         <= BUS_IDLE;
        end
        S_CAP: begin
          oRes[31:0] <= idat;
          oRes_valid <= 1'b1;
          state      <= S_OUT;
        end
        S_OUT: begin
          if (iRes_ready) begin
            oRes_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          bus   <= BUS_IDLE;
        end
      endcase
    end
  end

  assign oChipselect_n = bus.cs_n;
  assign oWrite_n      = bus.write_n;
  assign oRead_n       = bus.read_n;
  assign oAddress      = bus.addr;
  assign odat          = bus.dat;

endmodule

// File: tb/tb_present_bus_master.sv
// Scoreboard bench: register-slave + PRESENT-80 model, random streams.
module tb_present_bus_master;

  localparam int LAT = 34;
  localparam int P   = 10;

  logic        clk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iKey_valid = 1'b0;
  logic        oKey_ready;
  logic [79:0] iKey = '0;
  logic        iBlk_valid = 1'b0;
  logic        oBlk_ready;
  logic [63:0] iBlk = '0;
  logic        oRes_valid;
  logic        iRes_ready = 1'b0;
  logic [63:0] oRes;
  logic        oChipselect_n;
  logic        oWrite_n;
  logic        oRead_n;
  logic [2:0]  oAddress;
  logic [31:0] odat;
  logic [31:0] idat = '0;
  logic        oBusy;
`ifdef PRESENT_BUS_MASTER_DONE_EN
  logic        iDone = 1'b0;
`endif

  present_bus_master #(.LATENCY(LAT), .CNT_W(8)) dut (
    .clk          (clk),
    .iReset_n     (iReset_n),
    .iKey_valid   (iKey_valid),
    .oKey_ready   (oKey_ready),
    .iKey         (iKey),
    .iBlk_valid   (iBlk_valid),
    .oBlk_ready   (oBlk_ready),
    .iBlk         (iBlk),
    .oRes_valid   (oRes_valid),
    .iRes_ready   (iRes_ready),
    .oRes         (oRes),
    .oChipselect_n(oChipselect_n),
    .oWrite_n     (oWrite_n),
    .oRead_n      (oRead_n),
    .oAddress     (oAddress),
    .odat         (odat),
    .idat         (idat),
`ifdef PRESENT_BUS_MASTER_DONE_EN
    .iDone        (iDone),
`endif
    .oBusy        (oBusy)
  );

  always #(P/2) clk = ~clk;

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;
      4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;
      4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;
      4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;
      4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(
    input logic [79:0] k_in,
    input logic [63:0] pt
  );
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    k = k_in;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
      t = '0;
      for (int j = 0; j < 64; j++)
        t[(j == 63) ? 63 : (j * 16) % 63] = s[j];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Peripheral model: registers, load-triggered cipher, registered reads
  logic [79:0] s_key = '0;
  logic [63:0] s_dat = '0;
  logic [63:0] s_res = '0;
  logic        s_load = 1'b0;

  always @(posedge clk) begin
    if (!oChipselect_n && !oWrite_n) begin
      case (oAddress)
        3'd0: begin
          s_load <= odat[0];
          if (odat[0]) s_res <= present80(s_key, s_dat);
        end
        3'd1: s_key[15:0]  <= odat[15:0];
        3'd2: s_key[47:16] <= odat;
        3'd3: s_key[79:48] <= odat;
        3'd4: s_dat[31:0]  <= odat;
        3'd5: s_dat[63:32] <= odat;
        default: ;
      endcase
    end else if (!oChipselect_n && oRead_n) begin
      s_load <= 1'b0;
    end
    if (!oChipselect_n && !oRead_n) begin
      if (s_load) idat <= 32'hDEADBEEF;
      else if (oAddress == 3'd7) idat <= s_res[63:32];
      else if (oAddress == 3'd6) idat <= s_res[31:0];
      else idat <= 32'h0;
    end
  end

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          kw;
    time         t;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [79:0] cur_key = '0;
  bit          pend_key = 1'b0;
  int          rdy_mode = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Downstream ready: always, random, or 5-cycle stall per result
  initial begin
    int stall = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: iRes_ready = 1'b1;
        1: iRes_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (oRes_valid) begin
            if (stall < 5) begin
              iRes_ready = 1'b0;
              stall++;
            end else begin
              iRes_ready = 1'b1;
            end
          end else begin
            stall = 0;
            iRes_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: bus key-write count, result latency, hold, value
  initial begin
    int          kw = 0;
    int          vcyc = 0;
    bit          seen = 1'b0;
    logic [63:0] held = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!iReset_n) begin
        kw = 0;
        vcyc = 0;
        seen = 1'b0;
        continue;
      end
      if (!oChipselect_n && !oWrite_n &&
          oAddress >= 3'd1 && oAddress <= 3'd3) begin
        kw++;
        if (oAddress == 3'd1)
          chk("key_lo_zext", 64'(odat[31:16]), 64'h0);
      end
      if (oRes_valid) begin
        if (!seen) begin
          seen = 1'b1;
          vcyc = 0;
          held = oRes;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0h required=none",
                     oRes);
          end else begin
            chk("latency", 64'(($time - exp_q[0].t - P/2) / P),
                64'(exp_q[0].lat));
          end
        end else begin
          chk("res_hold", oRes, held);
        end
        chk("blk_ready_low", 64'(oBlk_ready), 64'h0);
        vcyc++;
        if (iRes_ready) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("result", oRes, e.res);
            chk("key_writes", 64'(kw), 64'(e.kw));
            if (rdy_mode == 2)
              chk("valid_hold_cycles", 64'(vcyc), 64'd6);
          end
          seen = 1'b0;
          kw = 0;
        end
      end
    end
  end

  task automatic send(input bit wk, input logic [79:0] k,
                      input bit wb, input logic [63:0] pt);
    int n = 0;
    @(negedge clk);
    iKey_valid = wk;
    iKey       = k;
    iBlk_valid = wb;
    iBlk       = pt;
    while (!(oKey_ready && oBlk_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL handshake_timeout actual=%0d required=<300", n);
      iKey_valid = 1'b0;
      iBlk_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (wk) begin
        cur_key  = k;
        pend_key = 1'b1;
      end
      if (wb) begin
        exp_q.push_back('{present80(cur_key, pt),
                          (pend_key ? 10 : 7) + LAT,
                          pend_key ? 3 : 0, $time});
        pend_key = 1'b0;
      end
      #1;
      iKey_valid = 1'b0;
      iBlk_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_cs_n"},    64'(oChipselect_n), 64'h1);
    chk({tag, "_write_n"}, 64'(oWrite_n),      64'h1);
    chk({tag, "_read_n"},  64'(oRead_n),       64'h1);
    chk({tag, "_addr"},    64'(oAddress),      64'h0);
    chk({tag, "_odat"},    64'(odat),          64'h0);
    chk({tag, "_busy"},    64'(oBusy),         64'h0);
    chk({tag, "_valid"},   64'(oRes_valid),    64'h0);
  endtask

  initial begin
    logic [79:0] k;
    logic [63:0] d;
    int          r;
    repeat (3) @(negedge clk);
    chk_bus_idle("reset");
    chk("reset_res", oRes, 64'h0);
    chk("reset_key_ready", 64'(oKey_ready), 64'h1);
    chk("reset_blk_ready", 64'(oBlk_ready), 64'h1);
    @(negedge clk);
    iReset_n = 1'b1;

    // Known-answer vectors, key and block together
    send(1'b1, 80'h0, 1'b1, 64'h0);
    exp_q[exp_q.size()-1].res = 64'h5579C1387B228445;
    drain();
    send(1'b1, {80{1'b1}}, 1'b1, {64{1'b1}});
    exp_q[exp_q.size()-1].res = 64'h3333DCD3213210D2;
    drain();

    // Block without new key
    send(1'b0, 80'h0, 1'b1, {$urandom, $urandom});
    drain();

    // Key alone, block later
    send(1'b1, {16'($urandom), $urandom, $urandom}, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    send(1'b0, 80'h0, 1'b1, {$urandom, $urandom});
    drain();

    // Downstream stall
    rdy_mode = 2;
    send(1'b0, 80'h0, 1'b1, {$urandom, $urandom});
    drain();
    rdy_mode = 0;

    // Reset while waiting on the core
    send(1'b0, 80'h0, 1'b1, {$urandom, $urandom});
    repeat (12) @(negedge clk);
    iReset_n = 1'b0;
    #1;
    chk_bus_idle("abort");
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_valid", 64'(oRes_valid), 64'h0);
    iReset_n = 1'b1;
    send(1'b0, 80'h0, 1'b1, {$urandom, $urandom});
    drain();

    // Random traffic
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 3);
      k = {16'($urandom), $urandom, $urandom};
      d = {$urandom, $urandom};
      send(r <= 1, k, r != 0, d);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
